// File: rtl/shift_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shift_arbiter_pkg
// Shared definitions for the two-requester shift arbiter:
//   - datapath widths (operand/result, shift amount, requester index)
//   - shift operation encodings
//   - small decode helpers used by the arbiter when steering the shift core
// -----------------------------------------------------------------------------
package shift_arbiter_pkg;

  localparam int SA_DATA_W  = 32;  // operand / result width
  localparam int SA_SHAMT_W = 5;   // log2(SA_DATA_W)
  localparam int SA_NUM_REQ = 2;   // number of requesters
  localparam int SA_ID_W    = 1;   // width of a requester index

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_RSV = 2'b10,  // reserved encoding, behaves as SLL
    OP_SRA = 2'b11
  } shift_op_e;

  // Right shifts are done by mirroring the operand around a left shifter.
  function automatic logic op_is_right(input logic [1:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Bit shifted in at the vacated end: sign bit for SRA, zero otherwise.
  function automatic logic op_fill(input logic [1:0] op, input logic msb);
    return (op == OP_SRA) && msb;
  endfunction

endpackage

// File: rtl/shift_core_32b.sv
// -----------------------------------------------------------------------------
// shift_core_32b
// Purely combinational 32-bit logarithmic left shifter with optional
// bit-reversal on input and output, so the same five stages serve SLL, SRL
// and SRA.
//
// Ports:
//   data_i  [31:0] operand
//   shamt_i [4:0]  shift amount; bit k enables the 2**k stage
//   fill_i         bit inserted into each vacated position
//   rev_i          1 = mirror operand before and result after the shifter
//   data_o  [31:0] shifted result
// -----------------------------------------------------------------------------
module shift_core_32b
  import shift_arbiter_pkg::*;
(
  input  logic [SA_DATA_W-1:0]  data_i,
  input  logic [SA_SHAMT_W-1:0] shamt_i,
  input  logic                  fill_i,
  input  logic                  rev_i,
  output logic [SA_DATA_W-1:0]  data_o
);

  // stage[0] is the (possibly mirrored) operand, stage[k+1] follows the 2**k step
  logic [SA_SHAMT_W:0][SA_DATA_W-1:0] stage;
  logic [SA_DATA_W-1:0]               data_rev;
  logic [SA_DATA_W-1:0]               out_rev;

  genvar gi;

  generate
    for (gi = 0; gi < SA_DATA_W; gi++) begin : g_mirror
      assign data_rev[gi] = data_i[SA_DATA_W-1-gi];
      assign out_rev[gi]  = stage[SA_SHAMT_W][SA_DATA_W-1-gi];
    end
  endgenerate

  assign stage[0] = rev_i ? data_rev : data_i;

  // Each stage shifts left by a power of two, filling the low bits explicitly.
  generate
    for (gi = 0; gi < SA_SHAMT_W; gi++) begin : g_stage
      localparam int S = 1 << gi;
      assign stage[gi+1] = shamt_i[gi]
                           ? {stage[gi][SA_DATA_W-1-S:0], {S{fill_i}}}
                           : stage[gi];
    end
  endgenerate

  assign data_o = rev_i ? out_rev : stage[SA_SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Two requesters share one combinational shift core. One request is granted
// per cycle whenever the single-entry result register is free (empty or
// being drained this cycle). The accepted operation is shifted in the same
// cycle and its result appears on the response port one cycle later.
//
// Build option:
//   SHIFT_ARB_RR_EN defined   -> round-robin: on contention the requester that
//                                was not granted last wins.
//   SHIFT_ARB_RR_EN undefined -> fixed priority: req0 always wins.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o     request handshake, N = 0,1
//   reqN_data_i, reqN_shamt_i       operand and shift amount
//   reqN_op_i                       00 SLL, 01 SRL, 11 SRA, 10 as SLL
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_data_o                      shifted result
//   rsp_id_o                        requester that issued the result
// -----------------------------------------------------------------------------
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = SA_DATA_W,
  parameter int SHAMT_W = SA_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [DATA_W-1:0]  req0_data_i,
  input  logic [SHAMT_W-1:0] req0_shamt_i,
  input  logic [1:0]         req0_op_i,

  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [DATA_W-1:0]  req1_data_i,
  input  logic [SHAMT_W-1:0] req1_shamt_i,
  input  logic [1:0]         req1_op_i,

  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_data_o,
  output logic [SA_ID_W-1:0] rsp_id_o
);

  // Requester-indexed views of the request ports
  logic [SA_NUM_REQ-1:0] req_valid;
  logic [DATA_W-1:0]     req_data  [SA_NUM_REQ];
  logic [SHAMT_W-1:0]    req_shamt [SA_NUM_REQ];
  logic [1:0]            req_op    [SA_NUM_REQ];

  logic [SA_NUM_REQ-1:0] gnt;
  logic [SA_NUM_REQ-1:0] ready;
  logic                  slot_free;
  logic                  accept;
  logic [SA_ID_W-1:0]    acc_id;

  logic [DATA_W-1:0]     sel_data;
  logic [SHAMT_W-1:0]    sel_shamt;
  logic [1:0]            sel_op;
  logic [DATA_W-1:0]     core_out;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q,  rsp_data_d;
  logic [SA_ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic [SA_ID_W-1:0]    last_q,      last_d;

  assign req_valid    = {req1_valid_i, req0_valid_i};
  assign req_data[0]  = req0_data_i;
  assign req_data[1]  = req1_data_i;
  assign req_shamt[0] = req0_shamt_i;
  assign req_shamt[1] = req1_shamt_i;
  assign req_op[0]    = req0_op_i;
  assign req_op[1]    = req1_op_i;

  // The register can take a new result if it is empty or drains this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready_i;

  // Grant depends only on the valids and the last-grant pointer.
  always_comb begin
    gnt = '0;
`ifdef SHIFT_ARB_RR_EN
    if (req_valid[0] && req_valid[1]) begin
      if (last_q == 1'b1) gnt[0] = 1'b1;
      else                gnt[1] = 1'b1;
    end else begin
      gnt = req_valid;
    end
`else
    if (req_valid[0])      gnt[0] = 1'b1;
    else if (req_valid[1]) gnt[1] = 1'b1;
`endif
  end

  // Ready is forced low while reset is asserted so nothing is taken then.
  genvar gi;
  generate
    for (gi = 0; gi < SA_NUM_REQ; gi++) begin : g_ready
      assign ready[gi] = gnt[gi] && slot_free && !rst_i;
    end
  endgenerate

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];

  // Grants are one-hot and imply valid, so ready alone identifies the accept.
  assign accept = |ready;
  assign acc_id = ready[1];

  assign sel_data  = req_data[acc_id];
  assign sel_shamt = req_shamt[acc_id];
  assign sel_op    = req_op[acc_id];

  shift_core_32b u_core (
    .data_i  (sel_data),
    .shamt_i (sel_shamt),
    .fill_i  (op_fill(sel_op, sel_data[DATA_W-1])),
    .rev_i   (op_is_right(sel_op)),
    .data_o  (core_out)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    if (accept) begin
      // Covers both an empty slot and a drain-and-refill in the same cycle.
      rsp_valid_d = 1'b1;
      rsp_data_d  = core_out;
      rsp_id_d    = acc_id;
      last_d      = acc_id;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      last_q      <= 1'b1;  // req0 wins the first contention
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Randomized and directed stimulus for shift_arbiter. A reference model
// predicts the readies each cycle and, on every accept, pushes the expected
// result into a scoreboard queue; the response side pops and compares
// whenever a result is presented. Works with or without SHIFT_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rsp_ready_i = 1'b1;

  // Requester drive state
  logic        v [2];
  logic [31:0] d [2];
  logic [4:0]  s [2];
  logic [1:0]  o [2];
  bit          dir_en [2];
  logic [31:0] dir_exp [2];

  logic        req0_ready_o, req1_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [0:0]  rsp_id_o;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (v[0]),
    .req0_ready_o (req0_ready_o),
    .req0_data_i  (d[0]),
    .req0_shamt_i (s[0]),
    .req0_op_i    (o[0]),
    .req1_valid_i (v[1]),
    .req1_ready_o (req1_ready_o),
    .req1_data_i  (d[1]),
    .req1_shamt_i (s[1]),
    .req1_op_i    (o[1]),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_id_o     (rsp_id_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural shift: plain SystemVerilog operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] x,
                                            input logic [4:0] sh,
                                            input logic [1:0] op);
    case (op)
      2'b01:   return x >> sh;
      2'b11:   return $signed(x) >>> sh;
      default: return x << sh;
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  bit started     = 1'b0;
  bit m_rsp_valid = 1'b0;  // model: result register occupied
  bit m_zero      = 1'b1;  // model: no result loaded since reset
  bit m_last      = 1'b1;  // model: last granted requester
  bit acc [2];             // DUT handshake seen for the coming edge

  // Reference model + scoreboard, evaluated mid-cycle for the next rising edge
  always @(negedge clk) begin : model
    bit   slot_free, has, pick;
    bit   e_rdy [2];
    exp_t e;
    if (started) begin
      // Response side
      check(rsp_valid_o === m_rsp_valid, "rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_rsp_valid});
      if (m_rsp_valid) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "sb_underflow", rsp_data_o, 32'h0);
        end else begin
          check(rsp_data_o === sb_q[0].data, "rsp_data", rsp_data_o, sb_q[0].data);
          check(rsp_id_o === sb_q[0].id, "rsp_id", {31'b0, rsp_id_o}, {31'b0, sb_q[0].id});
          if (rsp_ready_i) begin
            $display("rsp id=%0d data=%08h", rsp_id_o, rsp_data_o);
            void'(sb_q.pop_front());
          end
        end
      end else if (m_zero) begin
        check(rsp_data_o === 32'h0, "rsp_data_rst", rsp_data_o, 32'h0);
        check(rsp_id_o === 1'b0, "rsp_id_rst", {31'b0, rsp_id_o}, 32'h0);
      end

      // Request side: prefer the requester not granted last (RR) or req0
      slot_free = !m_rsp_valid || rsp_ready_i;
      has       = v[0] || v[1];
`ifdef SHIFT_ARB_RR_EN
      pick = (v[0] && v[1]) ? !m_last : (v[1] && !v[0]);
`else
      pick = !v[0];
`endif
      e_rdy[0] = has && slot_free && !rst_i && (pick == 1'b0);
      e_rdy[1] = has && slot_free && !rst_i && (pick == 1'b1);
      check({req1_ready_o, req0_ready_o} === {e_rdy[1], e_rdy[0]}, "ready",
            {30'b0, req1_ready_o, req0_ready_o}, {30'b0, e_rdy[1], e_rdy[0]});
      acc[0] = v[0] && req0_ready_o;
      acc[1] = v[1] && req1_ready_o;

      if (rst_i) begin
        m_rsp_valid = 1'b0;
        m_zero      = 1'b1;
        m_last      = 1'b1;
        sb_q.delete();
      end else if (e_rdy[0] || e_rdy[1]) begin
        e.id   = pick;
        e.data = dir_en[pick] ? dir_exp[pick] : ref_shift(d[pick], s[pick], o[pick]);
        sb_q.push_back(e);
        m_last      = pick;
        m_rsp_valid = 1'b1;
        m_zero      = 1'b0;
      end else if (rsp_ready_i) begin
        m_rsp_valid = 1'b0;
      end
    end
  end

  task automatic present(input int n, input logic [31:0] dd, input logic [4:0] ss,
                         input logic [1:0] oo, input bit use_dir, input logic [31:0] ex);
    v[n] = 1'b1; d[n] = dd; s[n] = ss; o[n] = oo;
    dir_en[n] = use_dir; dir_exp[n] = ex;
  endtask

  task automatic rand_req(input int n);
    present(n, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b0, 32'h0);
  endtask

  // Run until every presented request has been accepted (bounded)
  task automatic drain_reqs();
    int k = 0;
    while ((v[0] || v[1]) && k < 100) begin
      @(posedge clk); #1; k++;
      for (int n = 0; n < 2; n++) if (acc[n]) begin v[n] = 1'b0; dir_en[n] = 1'b0; end
    end
    check(!(v[0] || v[1]), "drain_timeout", {31'b0, v[0] || v[1]}, 32'h0);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; d[n] = '0; s[n] = '0; o[n] = '0; dir_en[n] = 1'b0; dir_exp[n] = '0;
      acc[n] = 1'b0;
    end
    // Request held during reset must not be taken until reset releases
    present(0, 32'h0000_0001, 5'd31, 2'b00, 1'b1, 32'h8000_0000);
    @(posedge clk); started = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0;
    drain_reqs();

    // Directed operations
    present(1, 32'h8000_0000, 5'd4, 2'b11, 1'b1, 32'hF800_0000); drain_reqs();
    present(0, 32'h8000_0000, 5'd4, 2'b01, 1'b1, 32'h0800_0000); drain_reqs();
    for (int op = 0; op < 4; op++) begin
      present(op % 2, 32'hDEAD_BEEF, 5'd0, 2'(op), 1'b1, 32'hDEAD_BEEF); drain_reqs();
    end
    present(0, 32'h0000_0001, 5'd1, 2'b10, 1'b1, 32'h0000_0002); drain_reqs();

    // Contention, both valid continuously, consumer always ready
    rand_req(0); rand_req(1);
    repeat (12) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) if (acc[n]) rand_req(n);
    end
    v[0] = 1'b0;  // req1 must now get through
    drain_reqs();

    // Backpressure: hold the result for 3 cycles with both requesting
    present(0, 32'h1234_5678, 5'd8, 2'b00, 1'b0, 32'h0); drain_reqs();
    rsp_ready_i = 1'b0;
    rand_req(0); rand_req(1);
    repeat (3) @(posedge clk);
    #1; rsp_ready_i = 1'b1;
    drain_reqs();

    // Reset while a result is pending and unconsumed
    present(1, 32'hCAFE_F00D, 5'd3, 2'b11, 1'b0, 32'h0); drain_reqs();
    rsp_ready_i = 1'b0;
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0; rsp_ready_i = 1'b1;
    rand_req(0); rand_req(1);
    @(posedge clk); #1;
    check(acc[0] == 1'b1, "post_rst_winner", {31'b0, acc[1]}, 32'h0);
    for (int n = 0; n < 2; n++) if (acc[n]) begin v[n] = 1'b0; end
    drain_reqs();

    // Randomized traffic with random backpressure
    repeat (400) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || acc[n]) begin
          if ($urandom_range(0, 3) != 0) rand_req(n);
          else v[n] = 1'b0;
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    rsp_ready_i = 1'b1;
    drain_reqs();
    repeat (3) @(posedge clk);
    #1;
    check(sb_q.size() == 0, "sb_leftover", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
